// File: rtl/grf_pkg.sv
// Shared defaults and clear-sweep state type for the parameterised register file.
package grf_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned NUM_RD_DEF = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/grf_clear_fsm.sv
// Clear-sweep controller: owns the IDLE/CLEAR state, the sweep index and Busy.
module grf_clear_fsm
    import grf_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              busy,
    output logic              start,
    output logic [ADDR_W-1:0] sweep_idx
);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    start   = 1'b1;
                end
            end
            CLEAR: begin
                // Natural wrap of the counter returns it to 0 on the final entry.
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == '1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == CLEAR);
    assign sweep_idx = cnt_q;

endmodule

// File: rtl/grf_param.sv
// Multi-read-port register file with pending bits and a sequential clear sweep.
// Optional same-cycle write-to-read bypass enabled by defining GRF_PARAM_BYPASS_EN.
module grf_param
    import grf_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned NUM_RD = NUM_RD_DEF
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] RA,
    output logic [NUM_RD*DATA_W-1:0] RD,
    output logic [NUM_RD-1:0]        RP,
    input  logic                     WE,
    input  logic [ADDR_W-1:0]        RW,
    input  logic [DATA_W-1:0]        WD,
    input  logic                     AE,
    input  logic [ADDR_W-1:0]        RAL,
    input  logic                     Clr,
    output logic                     Busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic              busy;
    logic              start;
    logic [ADDR_W-1:0] sweep_idx;

    grf_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .clr       (Clr),
        .busy      (busy),
        .start     (start),
        .sweep_idx (sweep_idx)
    );

    assign Busy = busy;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            regs_q <= '{default: '0};
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (busy) begin
            regs_d[sweep_idx] = '0;
        end else begin
            if (WE && RW != '0) begin
                regs_d[RW] = WD;
                pend_d[RW] = 1'b0;
            end
            // Allocate after write so a same-address allocate leaves the bit set.
            if (AE && RAL != '0) begin
                pend_d[RAL] = 1'b1;
            end
            if (start) begin
                pend_d = '0;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        logic              rp;

        assign ra = RA[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd = '0;
            rp = 1'b0;
            if (!busy && ra != '0) begin
                rd = regs_q[ra];
                rp = pend_q[ra];
`ifdef GRF_PARAM_BYPASS_EN
                if (WE && RW == ra) begin
                    rd = WD;
                    rp = 1'b0;
                end
`else
`endif
            end
        end

        assign RD[k*DATA_W +: DATA_W] = rd;
        assign RP[k]                  = rp;
    end

endmodule
